// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone memory slave.
package wb_pkg;

    localparam int WB_ADR_WIDTH = 16;
    localparam int WB_DAT_WIDTH = 16;

    // Width of a counter that must hold every value 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

    // One bus request as presented to the memory port.
    typedef struct packed {
        logic                    we;
        logic [WB_ADR_WIDTH-1:0] adr;
        logic [WB_DAT_WIDTH-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone slave bridging onto a request/grant memory port with
// in-order responses of variable latency. Tracks requests in flight, applies
// backpressure through stall, and swallows responses that belong to an
// aborted bus cycle.
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int adr_width       = WB_ADR_WIDTH,
    parameter int dat_width       = WB_DAT_WIDTH,
    parameter int max_outstanding = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cyc,
    input  logic                 stb,
    input  logic                 we,
    input  logic [adr_width-1:0] adr,
    input  logic [dat_width-1:0] dat_i,
    output logic [dat_width-1:0] dat_o,
    output logic                 ack,
    output logic                 stall,
    output logic                 mem_req,
    input  logic                 mem_gnt,
    output logic                 mem_we,
    output logic [adr_width-1:0] mem_adr,
    output logic [dat_width-1:0] mem_wdata,
    input  logic                 mem_rvalid,
    input  logic [dat_width-1:0] mem_rdata
);

    localparam int cnt_w = cnt_width(max_outstanding);
    typedef logic [cnt_w-1:0] cnt_t;
    localparam cnt_t max_cnt = cnt_t'(max_outstanding);
    localparam cnt_t cnt_one = cnt_t'(1);

    cnt_t    outstanding;
    cnt_t    discard;
    logic    cyc_q;
    logic    ack_q;
    logic    full;
    logic    accept;
    logic    rvalid_ok;
    logic    cyc_fall;
    logic    drop_rsp;
    logic    ack_next;
    wb_req_t req;

    // Request fields travel to the memory port untouched.
    assign req       = '{we: we, adr: adr, dat: dat_i};
    assign mem_we    = req.we;
    assign mem_adr   = req.adr;
    assign mem_wdata = req.dat;

    // Slot accounting and handshake decode.
    always_comb begin
        // NOTE: every signal gets a value on every path through always_comb,
        // otherwise synthesis infers a latch to hold the old value.
        full      = (outstanding == max_cnt) || (discard != '0);
        mem_req   = cyc & stb & ~full;
        stall     = cyc & (full | ~mem_gnt);
        accept    = mem_req & mem_gnt;
        // A response with nothing in flight is a protocol error and is ignored.
        rvalid_ok = mem_rvalid & (outstanding != '0);
        cyc_fall  = cyc_q & ~cyc;
        drop_rsp  = rvalid_ok & (discard != '0);
        ack_next  = rvalid_ok & cyc & (discard == '0);
    end

    // Requests accepted but not yet answered by the memory.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples values from before the edge, independent of block order.
        if (!rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, rvalid_ok})
                2'b10:   outstanding <= outstanding + cnt_one;
                2'b01:   outstanding <= outstanding - cnt_one;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Responses still owed to an aborted cycle; they must never be acked.
    always_ff @(posedge clk) begin
        if (!rst) begin
            discard <= '0;
        end else if (cyc_fall && outstanding != '0) begin
            discard <= outstanding - cnt_t'(rvalid_ok);
        end else if (drop_rsp) begin
            discard <= discard - cnt_one;
        end
    end

    // Previous cyc, used to spot the end of a bus cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_q <= 1'b0;
        end else begin
            cyc_q <= cyc;
        end
    end

    // Registered response: one ack per accepted request, data captured with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_q <= ack_next;
            if (ack_next) begin
                dat_o <= mem_rdata;
            end
        end
    end

    // A master that drops cyc has abandoned the cycle, so ack is masked then.
    assign ack = ack_q & cyc;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Self-checking bench for wb_mem_slave: a vector table, directed corner-case
// sequences and a randomized phase, all compared against a transaction-level
// model (a queue of in-flight requests, each tagged stale once its bus cycle
// ends).
module tb_wb_mem_slave;
    import wb_pkg::*;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_i, dat_o;
    logic          ack, stall, mem_req, mem_gnt, mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    wb_mem_slave #(.adr_width(AW), .dat_width(DW), .max_outstanding(MAXO)) dut (
        .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
        .dat_i(dat_i), .dat_o(dat_o), .ack(ack), .stall(stall),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    bit            stale_q[$];
    bit            exp_ack_pend = 1'b0;
    logic [DW-1:0] exp_dat = '0;
    bit            m_req;
    bit            checking = 1'b0;
    int            now = 0;

    // Memory emulator state.
    bit auto_mem = 1'b0;
    bit spur_en  = 1'b0;
    int lat_lo = 1, lat_hi = 1, last_due = 0;
    int mem_due[$];

    function automatic bit any_stale();
        foreach (stale_q[i]) if (stale_q[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Let combinational outputs settle and compare everything visible now.
    task automatic settle();
        bit busy;
        #1;
        busy  = any_stale() || (stale_q.size() == MAXO);
        m_req = cyc & stb & !busy;
        if (checking) begin
            check("stall", stall, cyc & (busy | !mem_gnt));
            check("mem_req", mem_req, m_req);
            check("ack", ack, exp_ack_pend & cyc);
            check("dat_o", dat_o, exp_dat);
            check("mem_we", mem_we, we);
            check("mem_adr", mem_adr, adr);
            check("mem_wdata", mem_wdata, dat_i);
        end
    endtask

    // Update the model from this cycle's inputs, then move to the next cycle.
    task automatic advance();
        bit            n_ack = 1'b0;
        logic [DW-1:0] n_dat = exp_dat;
        if (!rst) begin
            stale_q.delete();
            mem_due.delete();
            n_dat = '0;
        end else begin
            if (mem_rvalid && stale_q.size() > 0) begin
                if (!stale_q.pop_front() && cyc) begin
                    n_ack = 1'b1;
                    n_dat = mem_rdata;
                end
            end
            if (!cyc) foreach (stale_q[i]) stale_q[i] = 1'b1;
            if (m_req && mem_gnt) stale_q.push_back(1'b0);
            if (auto_mem && mem_req && mem_gnt) begin
                int due = now + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_due.push_back(due);
            end
        end
        @(posedge clk);
        exp_ack_pend = n_ack;
        exp_dat      = n_dat;
        now++;
        @(negedge clk);
    endtask

    task automatic drive(input logic c, input logic s, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic g, input logic rv,
                         input logic [DW-1:0] rd);
        cyc = c; stb = s; we = w; adr = a; dat_i = d;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
        settle();
    endtask

    // In-order memory: answers each accepted request after its latency.
    task automatic mem_next(output logic rv, output logic [DW-1:0] rd);
        rd = DW'($urandom);
        rv = 1'b0;
        if (mem_due.size() > 0 && mem_due[0] <= now) begin
            void'(mem_due.pop_front());
            rv = 1'b1;
        end else if (spur_en && mem_due.size() == 0) begin
            rv = ($urandom_range(0, 99) < 3);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
            advance();
        end
    endtask

    typedef struct {
        wb_req_t       req;
        logic          cyc, stb, gnt, rv;
        logic [DW-1:0] rd;
        logic          exp_stall, exp_req, exp_ack;
        logic [DW-1:0] exp_dat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic          rv;
        logic [DW-1:0] rd;
        int            sent, acks;
        bit            saw_stall;

        vecs[0] = '{'{1'b0, 16'h0100, 16'h0}, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{'{1'b0, 16'h0100, 16'h0}, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[2] = '{'{1'b0, 16'h0100, 16'h0}, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{'{1'b0, 16'h0104, 16'h0}, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{'{1'b0, 16'h0108, 16'h0}, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1111};
        vecs[5] = '{'{1'b0, 16'h0108, 16'h0}, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h2222};
        vecs[6] = '{'{1'b0, 16'h0108, 16'h0}, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 16'h2222};
        vecs[7] = '{'{1'b0, 16'h0108, 16'h0}, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h2222};
        vecs[8] = '{'{1'b1, 16'h010C, 16'h5A5A}, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h2222};

        // Power-on reset; outputs are unknown until the first reset edge.
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        checking = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        check("reset_ack", ack, 1'b0);
        check("reset_dat", dat_o, '0);
        check("reset_stall", stall, 1'b0);
        advance();

        // Vector table: handshake basics and a protocol-error response.
        foreach (vecs[i]) begin
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].req.we, vecs[i].req.adr, vecs[i].req.dat,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rd);
            check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            check($sformatf("vec%0d_req", i), mem_req, vecs[i].exp_req);
            check($sformatf("vec%0d_ack", i), ack, vecs[i].exp_ack);
            check($sformatf("vec%0d_dat", i), dat_o, vecs[i].exp_dat);
            advance();
        end
        idle(1);

        // Single read, response three cycles after accept.
        drive(1'b1, 1'b1, 1'b0, 16'h0010, '0, 1'b1, 1'b0, '0);
        check("sr_stall_accept", stall, 1'b0);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
            check("sr_stall_wait", stall, 1'b0);
            check("sr_no_early_ack", ack, 1'b0);
            advance();
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'hBEEF);
        check("sr_ack_not_same_cycle", ack, 1'b0);
        advance();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        check("sr_ack", ack, 1'b1);
        check("sr_dat", dat_o, 16'hBEEF);
        advance();
        idle(1);

        // Six back-to-back writes, memory latency five.
        auto_mem = 1'b1; lat_lo = 5; lat_hi = 5; last_due = 0;
        sent = 0; acks = 0; saw_stall = 1'b0;
        for (int t = 0; t < 40; t++) begin
            mem_next(rv, rd);
            drive(1'b1, sent < 6, 1'b1, AW'(16'h0200 + sent), DW'(16'hA000 + sent), 1'b1, rv, rd);
            if (ack) acks++;
            if (sent == 4 && stall) saw_stall = 1'b1;
            if (mem_req && mem_gnt) sent++;
            advance();
        end
        check("b2b_accepts", sent, 6);
        check("b2b_acks", acks, 6);
        check("b2b_stall_when_full", saw_stall, 1'b1);
        auto_mem = 1'b0;
        idle(1);

        // Grant backpressure for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'h0300, '0, 1'b0, 1'b0, '0);
            check("bp_stall", stall, 1'b1);
            advance();
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0300, '0, 1'b1, 1'b0, '0);
        check("bp_stall_on_grant", stall, 1'b0);
        check("bp_req_on_grant", mem_req, 1'b1);
        advance();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'hC0DE);
        advance();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        check("bp_ack", ack, 1'b1);
        check("bp_dat", dat_o, 16'hC0DE);
        advance();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        check("bp_single_ack", ack, 1'b0);
        advance();
        idle(1);

        // Abort: three reads in flight, cyc drops, new cycle must wait them out.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, AW'(16'h0400 + i), '0, 1'b1, 1'b0, '0);
            advance();
        end
        acks = 0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'h0480, '0, 1'b1, (i != 1), DW'(16'hDEAD + i));
            check("abort_stall", stall, 1'b1);
            if (ack) acks++;
            advance();
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0480, '0, 1'b1, 1'b0, '0);
        check("abort_resume_stall", stall, 1'b0);
        if (ack) acks++;
        advance();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h1234);
        if (ack) acks++;
        advance();
        check("abort_stale_acks", acks, 0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        check("abort_new_ack", ack, 1'b1);
        check("abort_new_dat", dat_o, 16'h1234);
        advance();
        idle(1);

        // Accept and response together, then behaviour at the full mark.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, AW'(16'h0500 + i), '0, 1'b1, 1'b0, '0);
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, AW'(16'h0510 + i), '0, 1'b1, 1'b1, DW'(16'h5100 + i));
            check("sim_stall", stall, 1'b0);
            advance();
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0520, '0, 1'b1, 1'b0, '0);
        check("fill_stall", stall, 1'b0);
        advance();
        drive(1'b1, 1'b1, 1'b0, 16'h0521, '0, 1'b1, 1'b1, 16'h5202);
        check("full_stall", stall, 1'b1);
        check("full_req", mem_req, 1'b0);
        advance();
        drive(1'b1, 1'b1, 1'b0, 16'h0521, '0, 1'b0, 1'b0, '0);
        check("nogrant_stall", stall, 1'b1);
        check("nogrant_req", mem_req, 1'b1);
        advance();
        drive(1'b1, 1'b1, 1'b0, 16'h0521, '0, 1'b1, 1'b0, '0);
        check("refill_stall", stall, 1'b0);
        advance();
        drive(1'b1, 1'b1, 1'b0, 16'h0522, '0, 1'b0, 1'b0, '0);
        check("full_nogrant_req", mem_req, 1'b0);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, DW'(16'h5300 + i));
            advance();
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        check("drain_last_ack", ack, 1'b1);
        check("drain_last_dat", dat_o, 16'h5303);
        advance();
        idle(1);

        // Reset in the middle of a burst.
        drive(1'b1, 1'b1, 1'b0, 16'h0600, '0, 1'b1, 1'b0, '0);
        advance();
        drive(1'b1, 1'b1, 1'b0, 16'h0602, '0, 1'b1, 1'b1, 16'h5555);
        advance();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h6666);
        check("rst_prior_ack", ack, 1'b1);
        advance();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        check("rst_ack", ack, 1'b0);
        check("rst_dat", dat_o, 16'h0000);
        advance();
        drive(1'b1, 1'b1, 1'b0, 16'h0610, '0, 1'b1, 1'b0, '0);
        check("rst_new_accept", mem_req & mem_gnt, 1'b1);
        advance();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h7777);
        advance();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        check("rst_new_ack", ack, 1'b1);
        check("rst_new_dat", dat_o, 16'h7777);
        advance();
        idle(1);

        // Randomized traffic against the model.
        auto_mem = 1'b1; spur_en = 1'b1; lat_lo = 1; lat_hi = 6; last_due = now;
        cyc = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            logic c;
            rst = ($urandom_range(0, 299) != 0);
            c   = cyc ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) != 0);
            mem_next(rv, rd);
            drive(c, $urandom_range(0, 9) < 7, 1'($urandom), AW'($urandom), DW'($urandom),
                  $urandom_range(0, 3) != 0, rv, rd);
            advance();
        end
        rst = 1'b1;
        auto_mem = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
